dmem_bridge: RTL
================

# dmem_bridge

Data-memory bridge downstream of the load/store unit. It takes the LSU's word-addressed request (store flag, word address, byte mask, pre-shifted store data) and runs it on a req/ack data bus. It returns the raw 32-bit load word, which the LSU shifts and extends. A one-entry store buffer lets stores retire in zero cycles. Loads stall the pipeline until data returns, and a watchdog abandons bus transfers that are never acknowledged.

## Interface
- `TIMEOUT`, 16: maximum consecutive unacknowledged bus-request cycles, range 1..255; 0 disables the watchdog.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: memory operation present this cycle; the request is held stable until `o_done`.
- `i_is_store` in 1: 1 = store, 0 = load.
- `i_addr` in 30: word address.
- `i_store_data` in 32: lane-aligned store data.
- `i_store_mask` in 4: byte enables for stores.
- `o_done` out 1: the operation completes this cycle (combinational); the pipeline stalls while `i_valid && !o_done`.
- `o_load_data` out 32: raw load word, registered, valid while `o_done` for a load; held until the next load completes.
- `o_err` out 1: one-cycle registered pulse on a watchdog abort.
- `o_bus_req` out 1: bus request (registered).
- `o_bus_we` out 1: bus write enable.
- `o_bus_addr` out 30: bus word address.
- `o_bus_wdata` out 32: bus write data.
- `o_bus_wmask` out 4: bus byte enables.
- `i_bus_ack` in 1: transfer accepted/completed, sampled at the rising edge while `o_bus_req=1`.
- `i_bus_rdata` in 32: read data, valid with `i_bus_ack` on reads.

## Operation
- **States:** IDLE, WR (buffered store on bus), RD (load on bus), RESP (load data ready).
- **Store buffer:** one entry (`we`, addr, data, mask). It is occupied exactly when state = WR.
- **IDLE, store:** `o_done=1` in the same cycle. The entry is latched; next state WR.
- **IDLE, load:** `o_done=0`; next state RD with addr latched.
- **WR:** drives the buffered entry with `o_bus_we=1`.
  - On ack with a store present: `o_done=1`, the new store overwrites the buffer, state stays WR (new transfer begins next cycle; `o_bus_req` stays high).
  - On ack with a load present: next state RD.
  - On ack otherwise: next state IDLE.
  - Without ack, any presented operation stalls (`o_done=0`).
- **RD:** drives `o_bus_we=0`, `o_bus_wmask=0`. On ack, `i_bus_rdata` is captured into `o_load_data`; next state RESP.
- **RESP:** `o_done=1` for the load; next state IDLE. A new operation is never accepted in RESP.
- **Loads never bypass** the buffered store: no forwarding, the load waits for the drain.
- **Watchdog:**
  - An 8-bit counter clears on entry to WR/RD and on ack; it increments each req cycle without ack.
  - When `TIMEOUT` consecutive unacked cycles end, the transfer is abandoned and `o_err` pulses next cycle.
  - An ack in the `TIMEOUT`-th cycle wins (no error).
  - WR abort: the store is dropped; next state follows the WR ack rules without accepting a store that cycle.
  - RD abort: `o_load_data` ← 0; next state RESP, with `o_err=1` coinciding with `o_done`.
- **Bus fields** are stable for the whole time `o_bus_req=1`.

## Timing
- **Reset values:** state IDLE; `o_bus_req`, `o_bus_we`, `o_bus_addr`, `o_bus_wdata`, `o_bus_wmask`, `o_load_data`, `o_err`, counter all 0. `o_done` is forced to 0 while `i_rst=1`.
- **Reset mid-transfer:** `o_bus_req` drops asynchronously and the buffered store or pending load is discarded.
- **Store latency:** 0 stall cycles if the buffer is empty. Otherwise the stall lasts until the buffer's ack cycle, and the store completes in that cycle.
- **Load latency**, with a zero-wait bus, when the request appears in cycle N with the buffer empty:
  - N+1: `o_bus_req` is high.
  - N+1 edge: ack sampled.
  - N+2: `o_done` and data valid. The pipeline stalls 2 cycles; each bus wait state adds 1.
- **Load behind a buffered store:** `o_bus_req` stays high continuously through the WR→RD transition.
- **`o_bus_req`** is 1 exactly in states WR and RD.

## Test plan
- **Store to idle bridge:** store addr 0x10, mask 4'b0011, data 0x0000BEEF, bus acks after 2 cycles. Require `o_done=1` in the request cycle; `o_bus_req` high for 3 cycles from the next cycle with `we=1`, addr 0x10, mask 0011; then IDLE.
- **Load, zero-wait:** load addr 0x20, bus returns 0xCAFEF00D with immediate ack. Require `o_done=1` exactly 2 cycles later with `o_load_data=0xCAFEF00D`, and `o_load_data` held afterwards.
- **Back-to-back stores:** store A then store B while A waits 3 cycles for ack. Require B stalls, B's `o_done` coincides with A's ack, `o_bus_req` never drops, and the second transfer carries B's fields.
- **Load behind buffered store:** store then load to the same address, ack after 1 wait. Require the write completes before the read is issued, no idle cycle on `o_bus_req`, and the load returns the bus read value.
- **Watchdog:** `TIMEOUT=4`, load, never ack. Require `o_bus_req` high exactly 4 cycles, then `o_done=1`, `o_err=1`, `o_load_data=0`. Also require that an ack in the 4th cycle gives no error.
- **Reset mid-RD:** assert `i_rst` while `o_bus_req=1`. Require `o_bus_req=0` immediately, all outputs at their reset values, and normal operation after release.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: LSU-to-bus data-memory bridge with a one-entry store buffer and a bus watchdog
// Ports: i_clk/i_rst (async, active-high) | LSU side: i_valid, i_is_store, i_addr,
//   i_store_data, i_store_mask -> o_done, o_load_data, o_err |
//   bus side: o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask <- i_bus_ack, i_bus_rdata
module dmem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_is_store,
    input  logic [29:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [3:0]  i_store_mask,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);
    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t     state, nxt;
    logic [7:0] cnt;
    logic       ack, tmo, done, take_st, take_ld;

    // ack and timeout only mean something while a transfer is on the bus;
    // an ack in the final watchdog cycle wins over the abort
    assign ack = o_bus_req && i_bus_ack;
    assign tmo = o_bus_req && !i_bus_ack && (TIMEOUT != 0) && (cnt == LAST);
    assign o_done = done && !i_rst;

    always_comb begin
        nxt = state;
        done = 1'b0;
        take_st = 1'b0;
        take_ld = 1'b0;
        case (state)
            IDLE: if (i_valid) begin
                take_st = i_is_store;
                take_ld = !i_is_store;
                done = i_is_store;
                nxt = i_is_store ? WR : RD;
            end
            WR: if (ack || tmo) begin
                // a store is only taken on a real ack; an aborted drain never accepts one
                if (i_valid && i_is_store && !tmo) begin
                    take_st = 1'b1;
                    done = 1'b1;
                end else if (i_valid && !i_is_store) begin
                    take_ld = 1'b1;
                    nxt = RD;
                end else begin
                    nxt = IDLE;
                end
            end
            RD: nxt = (ack || tmo) ? RESP : RD;
            default: begin
                done = 1'b1;
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt <= 8'd0;
            o_bus_req <= 1'b0;
            o_bus_we <= 1'b0;
            o_bus_addr <= 30'd0;
            o_bus_wdata <= 32'd0;
            o_bus_wmask <= 4'd0;
            o_load_data <= 32'd0;
            o_err <= 1'b0;
        end else begin
            state <= nxt;
            o_bus_req <= (nxt == WR) || (nxt == RD);
            o_err <= tmo;
            cnt <= (take_st || take_ld || ack || !o_bus_req) ? 8'd0 : cnt + 8'd1;
            if (take_st) begin
                o_bus_we <= 1'b1;
                o_bus_addr <= i_addr;
                o_bus_wdata <= i_store_data;
                o_bus_wmask <= i_store_mask;
            end else if (take_ld) begin
                o_bus_we <= 1'b0;
                o_bus_addr <= i_addr;
                o_bus_wdata <= 32'd0;
                o_bus_wmask <= 4'd0;
            end
            if (state == RD && (ack || tmo))
                o_load_data <= ack ? i_bus_rdata : 32'd0;
        end
    end
endmodule
